// File: rtl/vec_pipeline_ctrl_pkg.sv
// Shared types and operand-resolution helpers for the vector pipeline hazard controller.
package vec_pipe_pkg;

   localparam int REG_SEL_BITS = 4;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_t;

   typedef struct packed {
      logic                    valid;
      logic                    wr_en;
      logic [REG_SEL_BITS-1:0] rd;
      logic                    is_load;
   } stage_info_t;

   typedef struct packed {
      fwd_sel_t sel;
      logic     loadUse;
   } operand_res_t;

   localparam stage_info_t STAGE_BUBBLE = '0;

   function automatic logic stageMatch(input stage_info_t s, input logic [REG_SEL_BITS-1:0] r,
                                       input logic useR, input logic decValid);
      return s.valid & s.wr_en & (s.rd == r) & useR & decValid;
   endfunction

   // Youngest producer wins; a load that has not reached WB cannot be forwarded.
   function automatic operand_res_t resolveOperand(input stage_info_t exS, input stage_info_t memS,
                                                   input stage_info_t wbS,
                                                   input logic [REG_SEL_BITS-1:0] r,
                                                   input logic useR, input logic decValid);
      operand_res_t res;
      res.sel     = FWD_RF;
      res.loadUse = 1'b0;
      if (stageMatch(exS, r, useR, decValid)) begin
         if (exS.is_load) res.loadUse = 1'b1;
         else             res.sel     = FWD_EX;
      end else if (stageMatch(memS, r, useR, decValid)) begin
         if (memS.is_load) res.loadUse = 1'b1;
         else              res.sel     = FWD_MEM;
      end else if (stageMatch(wbS, r, useR, decValid)) begin
         res.sel = FWD_WB;
      end else begin
         res.sel = FWD_RF;
      end
      return res;
   endfunction

endpackage

// File: rtl/vec_pipeline_ctrl_if.sv
// Decode/pipeline control bundle between the vector ASIP datapath and its hazard controller.
interface vec_pipeline_ctrl_if import vec_pipe_pkg::*; #(parameter int CNT_W = 16);

   logic                    dec_valid;
   logic [REG_SEL_BITS-1:0] dec_rs1;
   logic [REG_SEL_BITS-1:0] dec_rs2;
   logic                    dec_use_rs1;
   logic                    dec_use_rs2;
   logic                    dec_wr_en;
   logic [REG_SEL_BITS-1:0] dec_rd;
   logic                    dec_is_load;
   logic                    branch_taken;
   logic                    mem_busy;

   logic                    stall_f;
   logic                    stall_d;
   logic                    flush_d;
   logic                    bubble_ex;
   logic [1:0]              fwd_sel1;
   logic [1:0]              fwd_sel2;
   logic                    wb_commit;
   logic [REG_SEL_BITS-1:0] wb_rd;
   logic [CNT_W-1:0]        stall_cnt;
   logic [CNT_W-1:0]        flush_cnt;

   modport master (
      output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
             dec_wr_en, dec_rd, dec_is_load, branch_taken, mem_busy,
      input  stall_f, stall_d, flush_d, bubble_ex, fwd_sel1, fwd_sel2,
             wb_commit, wb_rd, stall_cnt, flush_cnt
   );

   modport slave (
      input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
             dec_wr_en, dec_rd, dec_is_load, branch_taken, mem_busy,
      output stall_f, stall_d, flush_d, bubble_ex, fwd_sel1, fwd_sel2,
             wb_commit, wb_rd, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/vec_pipeline_ctrl_shadow_reg.sv
// One shadow pipeline stage: tracks writeback info of the instruction occupying that stage.
module hazard_shadow_reg import vec_pipe_pkg::*; (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        bubble,
   input  stage_info_t nextStage,
   output stage_info_t stage
);

   stage_info_t stageR;

   // reset dominates, then hold, then bubble insertion, otherwise advance
   always_ff @(posedge clk) begin
      if (!rst) begin
         stageR <= STAGE_BUBBLE;
      end else if (hold) begin
         stageR <= stageR;
      end else if (bubble) begin
         stageR <= STAGE_BUBBLE;
      end else begin
         stageR <= nextStage;
      end
   end

   assign stage = stageR;

endmodule

// File: rtl/vec_pipeline_ctrl.sv
// Hazard/pipeline controller: RAW forwarding, load-use stall, branch squash, memory freeze
// and saturating stall/flush counters for the F-D-EX-MEM-WB vector pipeline.
module vec_pipeline_ctrl import vec_pipe_pkg::*; #(
   parameter int CNT_W = 16
) (
   input logic                clk,
   input logic                rst,
   vec_pipeline_ctrl_if.slave pipe
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   stage_info_t      decStage, exStage, memStage, wbStage;
   operand_res_t     op1, op2;
   logic             stallF, stallD, flushD, bubbleEx;
   logic [CNT_W-1:0] stallCntR, flushCntR;

   // decode fields qualified by dec_valid so bubbles carry no stale register numbers
   always_comb begin
      decStage = STAGE_BUBBLE;
      if (pipe.dec_valid) begin
         decStage.valid   = 1'b1;
         decStage.wr_en   = pipe.dec_wr_en;
         decStage.rd      = pipe.dec_rd;
         decStage.is_load = pipe.dec_is_load;
      end else begin
         decStage = STAGE_BUBBLE;
      end
   end

   // hazard resolution; a memory freeze outranks a branch, which outranks load-use
   always_comb begin
      op1 = resolveOperand(exStage, memStage, wbStage, pipe.dec_rs1, pipe.dec_use_rs1, pipe.dec_valid);
      op2 = resolveOperand(exStage, memStage, wbStage, pipe.dec_rs2, pipe.dec_use_rs2, pipe.dec_valid);
      stallF   = 1'b0;
      stallD   = 1'b0;
      flushD   = 1'b0;
      bubbleEx = 1'b0;
      if (pipe.mem_busy) begin
         stallF = 1'b1;
         stallD = 1'b1;
      end else if (pipe.branch_taken) begin
         flushD   = 1'b1;
         bubbleEx = 1'b1;
      end else if (op1.loadUse || op2.loadUse) begin
         stallF   = 1'b1;
         stallD   = 1'b1;
         bubbleEx = 1'b1;
      end else begin
         stallF   = 1'b0;
         stallD   = 1'b0;
      end
   end

   // EX/MEM freeze during mem_busy while WB drains into a bubble
   hazard_shadow_reg uExShadow (
      .clk(clk), .rst(rst), .hold(pipe.mem_busy), .bubble(bubbleEx),
      .nextStage(decStage), .stage(exStage)
   );

   hazard_shadow_reg uMemShadow (
      .clk(clk), .rst(rst), .hold(pipe.mem_busy), .bubble(1'b0),
      .nextStage(exStage), .stage(memStage)
   );

   hazard_shadow_reg uWbShadow (
      .clk(clk), .rst(rst), .hold(1'b0), .bubble(pipe.mem_busy),
      .nextStage(memStage), .stage(wbStage)
   );

   // saturating performance counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         stallCntR <= '0;
         flushCntR <= '0;
      end else begin
         if (stallD && (stallCntR != CNT_MAX)) stallCntR <= stallCntR + CNT_ONE;
         else                                  stallCntR <= stallCntR;
         if (flushD && (flushCntR != CNT_MAX)) flushCntR <= flushCntR + CNT_ONE;
         else                                  flushCntR <= flushCntR;
      end
   end

   // every output is held at zero while reset is asserted
   always_comb begin
      if (rst) begin
         pipe.stall_f   = stallF;
         pipe.stall_d   = stallD;
         pipe.flush_d   = flushD;
         pipe.bubble_ex = bubbleEx;
         pipe.fwd_sel1  = op1.sel;
         pipe.fwd_sel2  = op2.sel;
         pipe.wb_commit = wbStage.valid & wbStage.wr_en;
         pipe.wb_rd     = wbStage.rd;
         pipe.stall_cnt = stallCntR;
         pipe.flush_cnt = flushCntR;
      end else begin
         pipe.stall_f   = 1'b0;
         pipe.stall_d   = 1'b0;
         pipe.flush_d   = 1'b0;
         pipe.bubble_ex = 1'b0;
         pipe.fwd_sel1  = 2'd0;
         pipe.fwd_sel2  = 2'd0;
         pipe.wb_commit = 1'b0;
         pipe.wb_rd     = '0;
         pipe.stall_cnt = '0;
         pipe.flush_cnt = '0;
      end
   end

endmodule

// File: tb/tb_vec_pipeline_ctrl.sv
// Directed, table-driven bench for vec_pipeline_ctrl plus a narrow-counter saturation instance.
module tb_vec_pipeline_ctrl;

   typedef struct packed {
      logic       rst, dv;
      logic [3:0] rs1, rs2;
      logic       u1, u2, we;
      logic [3:0] rd;
      logic       ld, br, mb;
   } in_t;

   typedef struct packed {
      logic [3:0]  flags;   // stall_f, stall_d, flush_d, bubble_ex
      logic [1:0]  f1, f2;
      logic        wc;
      logic [3:0]  wrd;
      logic [15:0] sc, fc;
   } out_t;

   typedef struct packed {
      in_t  in;
      out_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   vec_t tbl[$];
   out_t actOut;

   vec_pipeline_ctrl_if #(.CNT_W(16)) vi ();
   vec_pipeline_ctrl_if #(.CNT_W(4))  vs ();

   vec_pipeline_ctrl #(.CNT_W(16)) dut      (.clk(clk), .rst(rst), .pipe(vi));
   vec_pipeline_ctrl #(.CNT_W(4))  dutSmall (.clk(clk), .rst(rst), .pipe(vs));

   always #5 clk = ~clk;

   assign actOut = {vi.stall_f, vi.stall_d, vi.flush_d, vi.bubble_ex, vi.fwd_sel1, vi.fwd_sel2,
                    vi.wb_commit, vi.wb_rd, vi.stall_cnt, vi.flush_cnt};

   function automatic in_t ins(int r, int dv, int rs1, int rs2, int u1, int u2, int we, int rd,
                               int ld, int br, int mb);
      in_t x;
      x.rst = r[0];   x.dv = dv[0];   x.rs1 = rs1[3:0]; x.rs2 = rs2[3:0];
      x.u1 = u1[0];   x.u2 = u2[0];   x.we = we[0];     x.rd = rd[3:0];
      x.ld = ld[0];   x.br = br[0];   x.mb = mb[0];
      return x;
   endfunction

   function automatic in_t alu(int rd, int a, int b, int ua, int ub);
      return ins(1, 1, a, b, ua, ub, 1, rd, 0, 0, 0);
   endfunction

   function automatic in_t lod(int rd);
      return ins(1, 1, 0, 0, 0, 0, 1, rd, 1, 0, 0);
   endfunction

   function automatic in_t nop(int br, int mb);
      return ins(1, 0, 0, 0, 0, 0, 0, 0, 0, br, mb);
   endfunction

   function automatic out_t outs(int flags, int f1, int f2, int wc, int wrd, int sc, int fc);
      out_t o;
      o.flags = flags[3:0]; o.f1 = f1[1:0]; o.f2 = f2[1:0]; o.wc = wc[0];
      o.wrd = wrd[3:0];     o.sc = sc[15:0]; o.fc = fc[15:0];
      return o;
   endfunction

   task automatic add(input in_t i, input out_t o);
      vec_t v;
      v.in = i;
      v.exp = o;
      tbl.push_back(v);
   endtask

   task automatic drive(input in_t i);
      rst = i.rst;
      vi.dec_valid = i.dv;    vi.dec_rs1 = i.rs1;      vi.dec_rs2 = i.rs2;
      vi.dec_use_rs1 = i.u1;  vi.dec_use_rs2 = i.u2;   vi.dec_wr_en = i.we;
      vi.dec_rd = i.rd;       vi.dec_is_load = i.ld;   vi.branch_taken = i.br;
      vi.mem_busy = i.mb;
   endtask

   initial begin
      vs.dec_valid = 1'b0;   vs.dec_rs1 = 4'd0;     vs.dec_rs2 = 4'd0;
      vs.dec_use_rs1 = 1'b0; vs.dec_use_rs2 = 1'b0; vs.dec_wr_en = 1'b0;
      vs.dec_rd = 4'd0;      vs.dec_is_load = 1'b0; vs.branch_taken = 1'b0;
      vs.mem_busy = 1'b0;
      drive(ins(0, 1, 5, 6, 1, 1, 1, 1, 0, 0, 0));

      // row: inputs for this cycle, outputs expected before the next rising edge
      add(ins(0, 1, 5, 6, 1, 1, 1, 1, 0, 0, 0), outs('b0000, 0, 0, 0, 0, 0, 0)); // in reset
      add(alu(1, 5, 6, 1, 1),                    outs('b0000, 0, 0, 0, 0, 0, 0)); // ADD r1
      add(alu(7, 1, 0, 1, 1),                    outs('b0000, 1, 0, 0, 0, 0, 0)); // r1 in EX
      add(alu(8, 1, 9, 1, 1),                    outs('b0000, 2, 0, 0, 0, 0, 0)); // r1 in MEM
      add(alu(10, 1, 11, 1, 1),                  outs('b0000, 3, 0, 1, 1, 0, 0)); // r1 in WB
      add(ins(1, 1, 12, 0, 1, 0, 1, 2, 1, 0, 0), outs('b0000, 0, 0, 1, 7, 0, 0)); // LOAD r2
      add(alu(13, 14, 2, 1, 1),                  outs('b1101, 0, 0, 1, 8, 0, 0)); // load-use #1
      add(alu(13, 14, 2, 1, 1),                  outs('b1101, 0, 0, 1, 10, 1, 0)); // load-use #2
      add(alu(13, 14, 2, 1, 1),                  outs('b0000, 0, 3, 1, 2, 2, 0)); // load in WB
      add(lod(3),                                outs('b0000, 0, 0, 0, 0, 2, 0)); // LOAD r3
      add(ins(1, 1, 3, 5, 1, 1, 1, 4, 0, 1, 0),  outs('b0011, 0, 0, 0, 0, 2, 0)); // branch wins
      add(nop(0, 1),                             outs('b1100, 0, 0, 1, 13, 2, 1)); // busy 1
      add(nop(0, 1),                             outs('b1100, 0, 0, 0, 0, 3, 1)); // busy 2
      add(nop(1, 1),                             outs('b1100, 0, 0, 0, 0, 4, 1)); // busy 3, br ignored
      add(nop(0, 0),                             outs('b0000, 0, 0, 0, 0, 5, 1)); // released
      add(nop(0, 0),                             outs('b0000, 0, 0, 1, 3, 5, 1)); // r3 commits
      add(alu(4, 0, 0, 0, 0),                    outs('b0000, 0, 0, 0, 0, 5, 1)); // r4 (a)
      add(alu(4, 0, 0, 0, 0),                    outs('b0000, 0, 0, 0, 0, 5, 1)); // r4 (b)
      add(alu(6, 4, 4, 1, 1),                    outs('b0000, 1, 1, 0, 0, 5, 1)); // youngest wins
      add(alu(9, 4, 4, 0, 1),                    outs('b0000, 0, 2, 1, 4, 5, 1)); // rs1 unused
      add(lod(5),                                outs('b0000, 0, 0, 1, 4, 5, 1)); // LOAD r5
      add(ins(1, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0),  outs('b0000, 0, 0, 1, 6, 5, 1)); // dec_valid=0
      add(ins(0, 1, 5, 0, 1, 0, 1, 1, 0, 0, 0),  outs('b0000, 0, 0, 0, 0, 0, 0)); // reset mid-run
      add(alu(1, 5, 9, 1, 1),                    outs('b0000, 0, 0, 0, 0, 0, 0)); // shadow empty

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive(tbl[i].in);
         #1;
         checks++;
         if (actOut !== tbl[i].exp) begin
            failures++;
            $display("FAIL vec%0d actual=%h required=%h (flags,f1,f2,wc,wrd,sc,fc)",
                     i, actOut, tbl[i].exp);
         end
      end

      // narrow counter under a continuous freeze must stop at 15
      @(negedge clk);
      vs.mem_busy = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         checks++;
         if (vs.stall_cnt !== ((k > 15) ? 4'd15 : 4'(k)) || vs.stall_d !== 1'b1) begin
            failures++;
            $display("FAIL sat%0d actual cnt=%0d stall_d=%b required cnt=%0d stall_d=1",
                     k, vs.stall_cnt, vs.stall_d, (k > 15) ? 15 : k);
         end
      end
      vs.mem_busy = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
